// File: rtl/bnn_pe_row_pipe.sv
// Binary neural network PE row: a linear pipeline of ROW_LENGTH stages. Each
// stage adds its XNOR-popcount contribution to a saturating signed partial sum.
// The whole row stalls when the output is held, and the weight register may
// only change while the row is empty.
module bnn_pe_row_pipe #(
  parameter int VEC_W      = 27,
  parameter int ROW_LENGTH = 7,
  parameter int WIDTH      = 14
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VEC_W*ROW_LENGTH-1:0]   activation_in,
  input  logic signed [WIDTH-1:0]       psum_in,
  input  logic                          weight_we,
  input  logic [VEC_W*ROW_LENGTH-1:0]   weight_in,
  output logic [VEC_W*ROW_LENGTH-1:0]   activation_out,
  output logic                          act_out_valid,
  output logic signed [WIDTH-1:0]       psum_out,
  output logic                          out_sat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int ACT_W = VEC_W * ROW_LENGTH;

  // Activation vectors are shifted left by one slice per stage, so the slice a
  // stage consumes is always the top slice of its input. Consumed slices become
  // constant zeros and are not carried forward.
  logic [ACT_W-1:0]        act_p  [ROW_LENGTH];
  logic signed [WIDTH-1:0] psum_p [ROW_LENGTH];
  logic                    sat_p  [ROW_LENGTH];
  logic                    vld_p  [ROW_LENGTH];

  logic [ACT_W-1:0]        act_src  [ROW_LENGTH];
  logic signed [WIDTH-1:0] psum_src [ROW_LENGTH];
  logic                    sat_src  [ROW_LENGTH];
  logic                    vld_src  [ROW_LENGTH];
  logic signed [WIDTH:0]   sum_w    [ROW_LENGTH];
  logic signed [WIDTH-1:0] psum_nxt [ROW_LENGTH];
  logic                    sat_nxt  [ROW_LENGTH];

  logic [ACT_W-1:0]        weight_q;
  logic                    advance;
  logic                    accept;

  function automatic logic signed [WIDTH:0] contrib(input logic [VEC_W-1:0] a,
                                                    input logic [VEC_W-1:0] w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < VEC_W; i++) begin
      if (a[i] == w[i]) cnt++;
    end
    return (WIDTH+1)'(2 * cnt - VEC_W);
  endfunction

  function automatic logic overflowed(input logic signed [WIDTH:0] s);
    return s[WIDTH] ^ s[WIDTH-1];
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH:0] s);
    if (overflowed(s)) begin
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return s[WIDTH-1:0];
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign psum_out  = psum_p[ROW_LENGTH-1];
  assign out_sat   = sat_p[ROW_LENGTH-1];
  assign out_valid = vld_p[ROW_LENGTH-1];

  // Per-stage inputs, widened sum and clamped result.
  always_comb begin
    act_src[0]  = activation_in;
    psum_src[0] = psum_in;
    sat_src[0]  = 1'b0;
    vld_src[0]  = in_valid;
    for (int k = 1; k < ROW_LENGTH; k++) begin
      act_src[k]  = act_p[k-1];
      psum_src[k] = psum_p[k-1];
      sat_src[k]  = sat_p[k-1];
      vld_src[k]  = vld_p[k-1];
    end
    for (int k = 0; k < ROW_LENGTH; k++) begin
      sum_w[k]    = $signed({psum_src[k][WIDTH-1], psum_src[k]})
                  + contrib(act_src[k][ACT_W-1 -: VEC_W],
                            weight_q[VEC_W*(ROW_LENGTH-k)-1 -: VEC_W]);
      psum_nxt[k] = saturate(sum_w[k]);
      sat_nxt[k]  = sat_src[k] | overflowed(sum_w[k]);
    end
  end

  // Row is busy while any stage holds a valid item.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < ROW_LENGTH; k++) begin
      busy = busy | vld_p[k];
    end
  end

  // Pipeline stage registers; all stages advance or hold together.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < ROW_LENGTH; k++) begin
        act_p[k]  <= '0;
        psum_p[k] <= '0;
        sat_p[k]  <= 1'b0;
        vld_p[k]  <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < ROW_LENGTH; k++) begin
        act_p[k]  <= act_src[k] << VEC_W;
        psum_p[k] <= psum_nxt[k];
        sat_p[k]  <= sat_nxt[k];
        vld_p[k]  <= vld_src[k];
      end
    end
  end

  // Forward each accepted activation vector to the row below.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      activation_out <= '0;
      act_out_valid  <= 1'b0;
    end else begin
      act_out_valid <= accept;
      if (accept) activation_out <= activation_in;
    end
  end

  // Weights change only when the row is empty and nothing is being offered,
  // so every resident item sees one consistent weight set.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      weight_q <= '0;
    end else if (weight_we && !busy && !in_valid) begin
      weight_q <= weight_in;
    end
  end

endmodule

// File: tb/tb_bnn_pe_row_pipe.sv
// Directed testbench for bnn_pe_row_pipe at VEC_W=27, ROW_LENGTH=7, WIDTH=14.
module tb_bnn_pe_row_pipe;

  localparam int ACT_W = 27 * 7;

  logic                    clk_in;
  logic                    rst_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [ACT_W-1:0]        activation_in;
  logic signed [13:0]      psum_in;
  logic                    weight_we;
  logic [ACT_W-1:0]        weight_in;
  logic [ACT_W-1:0]        activation_out;
  logic                    act_out_valid;
  logic signed [13:0]      psum_out;
  logic                    out_sat;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  int n_cmp;
  int n_fail;

  bnn_pe_row_pipe #(.VEC_W(27), .ROW_LENGTH(7), .WIDTH(14)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .activation_in(activation_in), .psum_in(psum_in), .weight_we(weight_we),
    .weight_in(weight_in), .activation_out(activation_out),
    .act_out_valid(act_out_valid), .psum_out(psum_out), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one item on an idle row and wait (bounded) for its result.
  task automatic run_item(input logic [ACT_W-1:0] a, input logic signed [13:0] p,
                          output logic signed [13:0] res, output logic sat,
                          output int lat, output logic aov1,
                          output logic [ACT_W-1:0] ao1, output logic aov2);
    @(negedge clk_in);
    activation_in = a; psum_in = p; in_valid = 1'b1; out_ready = 1'b1;
    aov2 = 1'bx;
    @(negedge clk_in);
    in_valid = 1'b0;
    aov1 = act_out_valid; ao1 = activation_out; lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk_in);
      lat++;
      if (lat == 2) aov2 = act_out_valid;
    end
    res = psum_out; sat = out_sat;
  endtask

  task automatic load_weights(input logic [ACT_W-1:0] w);
    for (int c = 0; c < 20 && busy; c++) @(negedge clk_in);
    @(negedge clk_in);
    weight_we = 1'b1; weight_in = w; in_valid = 1'b0;
    @(negedge clk_in);
    weight_we = 1'b0;
  endtask

  task automatic test_reset();
    logic signed [13:0] r; logic s; int l; logic v1, v2; logic [ACT_W-1:0] ao;
    rst_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1; weight_we = 1'b0;
    activation_in = '0; weight_in = '0; psum_in = '0;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (act_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_act_out_valid: got %b expected 0", act_out_valid); end
    n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_out_sat: got %b expected 0", out_sat); end
    n_cmp++; if (psum_out !== 14'sd0) begin n_fail++; $display("FAIL rst_psum_out: got %0d expected 0", psum_out); end
    n_cmp++; if (activation_out !== '0) begin n_fail++; $display("FAIL rst_activation_out: got %h expected 0", activation_out); end
    rst_in = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    // Weights reset to zero: zero activations match every bit -> +189.
    run_item('0, 14'sd0, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== 14'sd189) begin n_fail++; $display("FAIL rst_weight_zero: got %0d expected 189", r); end
  endtask

  task automatic test_all_ones();
    logic signed [13:0] r; logic s; int l; logic v1, v2; logic [ACT_W-1:0] ao;
    logic [ACT_W-1:0] a;
    a = '1;
    run_item(a, 14'sd0, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== 14'sd189) begin n_fail++; $display("FAIL ones_psum: got %0d expected 189", r); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL ones_sat: got %b expected 0", s); end
    n_cmp++; if (l !== 7) begin n_fail++; $display("FAIL ones_latency: got %0d expected 7", l); end
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL ones_act_out_valid: got %b expected 1", v1); end
    n_cmp++; if (ao !== a) begin n_fail++; $display("FAIL ones_activation_out: got %h expected %h", ao, a); end
    n_cmp++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL ones_act_out_valid_drop: got %b expected 0", v2); end
    // Each slice with one mismatching bit: 7 * (2*26 - 27) = 175.
    for (int k = 0; k < 7; k++) a[27*k] = 1'b0;
    run_item(a, 14'sd0, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== 14'sd175) begin n_fail++; $display("FAIL partial_psum: got %0d expected 175", r); end
  endtask

  task automatic test_sat();
    logic signed [13:0] r; logic s; int l; logic v1, v2; logic [ACT_W-1:0] ao;
    run_item('0, 14'sd5, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== -14'sd184) begin n_fail++; $display("FAIL zeros_psum: got %0d expected -184", r); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL zeros_sat: got %b expected 0", s); end
    run_item('0, -14'sd8100, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== -14'sd8192) begin n_fail++; $display("FAIL neg_clamp_psum: got %0d expected -8192", r); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL neg_clamp_sat: got %b expected 1", s); end
    run_item('1, 14'sd8100, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== 14'sd8191) begin n_fail++; $display("FAIL pos_clamp_psum: got %0d expected 8191", r); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL pos_clamp_sat: got %b expected 1", s); end
  endtask

  task automatic test_slice_order();
    logic signed [13:0] r; logic s; int l; logic v1, v2; logic [ACT_W-1:0] ao;
    logic [ACT_W-1:0] a;
    a = '0;
    a[ACT_W-1 -: 27] = '1;
    run_item(a, 14'sd0, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== -14'sd135) begin n_fail++; $display("FAIL slice0_psum: got %0d expected -135", r); end
    // Stage 0 saturates first (8181+27 -> 8191), then six -27 steps -> 8029.
    run_item(a, 14'sd8181, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== 14'sd8029) begin n_fail++; $display("FAIL slice_order_psum: got %0d expected 8029", r); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL slice_order_sat: got %b expected 1", s); end
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      int sent, got, first_cyc, last_cyc, stall_left;
      logic signed [13:0] stall_val;
      logic signed [13:0] exp_v;
      sent = 0; got = 0; first_cyc = -1; last_cyc = -1; stall_left = 0; stall_val = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk_in);
        if (sent < 10) begin
          in_valid = 1'b1; activation_in = '1; psum_in = 14'(sent * 10 + pass * 200);
        end else begin
          in_valid = 1'b0;
        end
        out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
        #1;
        if (!out_ready) begin
          n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
          n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
          if (stall_left == 4) stall_val = psum_out;
          else begin
            n_cmp++; if (psum_out !== stall_val) begin n_fail++; $display("FAIL stall_psum_stable: got %0d expected %0d", psum_out, stall_val); end
          end
          stall_left--;
        end
        if (out_valid && out_ready) begin
          exp_v = 14'(got * 10 + pass * 200 + 189);
          n_cmp++; if (psum_out !== exp_v) begin n_fail++; $display("FAIL b2b_psum[%0d]: got %0d expected %0d", got, psum_out, exp_v); end
          if (got == 0) first_cyc = cyc;
          last_cyc = cyc;
          got++;
          if (pass == 1 && got == 1) stall_left = 4;
        end
        if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (got !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", got); end
      if (pass == 0) begin
        n_cmp++; if (last_cyc - first_cyc !== 9) begin n_fail++; $display("FAIL b2b_consecutive: got span %0d expected 9", last_cyc - first_cyc); end
      end
    end
  endtask

  task automatic test_weight_we();
    logic signed [13:0] r; logic s; int l; logic v1, v2; logic [ACT_W-1:0] ao;
    logic signed [13:0] res [2];
    int got;
    // Item A, then a weight write while busy (ignored), then item B.
    @(negedge clk_in);
    in_valid = 1'b1; activation_in = '1; psum_in = 14'sd0; out_ready = 1'b1;
    @(negedge clk_in);
    in_valid = 1'b0; weight_we = 1'b1; weight_in = '0;
    @(negedge clk_in);
    weight_we = 1'b0; in_valid = 1'b1; activation_in = '1; psum_in = 14'sd1;
    @(negedge clk_in);
    in_valid = 1'b0;
    got = 0; res[0] = '0; res[1] = '0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk_in);
      if (out_valid) begin res[got] = psum_out; got++; end
    end
    n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL busy_we_count: got %0d expected 2", got); end
    n_cmp++; if (res[0] !== 14'sd189) begin n_fail++; $display("FAIL busy_we_item_a: got %0d expected 189", res[0]); end
    n_cmp++; if (res[1] !== 14'sd190) begin n_fail++; $display("FAIL busy_we_item_b: got %0d expected 190", res[1]); end
    // Idle write of zero weights takes effect for the next item.
    load_weights('0);
    run_item('1, 14'sd0, r, s, l, v1, ao, v2);
    n_cmp++; if (r !== -14'sd189) begin n_fail++; $display("FAIL idle_we_new: got %0d expected -189", r); end
    // Write coinciding with in_valid is ignored.
    @(negedge clk_in);
    weight_we = 1'b1; weight_in = '1; in_valid = 1'b1; activation_in = '1; psum_in = 14'sd0;
    @(negedge clk_in);
    weight_we = 1'b0; in_valid = 1'b0;
    got = 0; r = '0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      @(negedge clk_in);
      if (out_valid) begin r = psum_out; got++; end
    end
    n_cmp++; if (r !== -14'sd189) begin n_fail++; $display("FAIL inval_we_ignored: got %0d expected -189", r); end
    load_weights('1);
  endtask

  task automatic test_async_reset();
    int cnt;
    // Case A: three items just accepted, reset between edges.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      in_valid = 1'b1; activation_in = '1; psum_in = 14'(i);
    end
    @(posedge clk_in);
    #2;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_a_pre_busy: got %b expected 1", busy); end
    n_cmp++; if (act_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_a_pre_aov: got %b expected 1", act_out_valid); end
    rst_in = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_a_busy: got %b expected 0", busy); end
    n_cmp++; if (act_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_a_aov: got %b expected 0", act_out_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_a_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (activation_out !== '0) begin n_fail++; $display("FAIL arst_a_act_out: got %h expected 0", activation_out); end
    n_cmp++; if (psum_out !== 14'sd0) begin n_fail++; $display("FAIL arst_a_psum: got %0d expected 0", psum_out); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_a_in_ready: got %b expected 1", in_ready); end
    cnt = 0;
    repeat (15) begin @(negedge clk_in); if (out_valid) cnt++; end
    n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL arst_a_stale: got %0d outputs expected 0", cnt); end
    // Case B: oldest item stalled at the output, reset between edges.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      in_valid = 1'b1; activation_in = '1; psum_in = 14'(i);
    end
    @(negedge clk_in);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk_in);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_b_pre_out_valid: got %b expected 1", out_valid); end
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_b_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_b_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1; out_ready = 1'b1;
    cnt = 0;
    repeat (15) begin @(negedge clk_in); if (out_valid) cnt++; end
    n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL arst_b_stale: got %0d outputs expected 0", cnt); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    load_weights('1);
    test_all_ones();
    test_sat();
    test_slice_order();
    test_back_to_back();
    test_weight_we();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_pe_row_pipe.md
BNN_PE_ROW_PIPE -- requirements
Module: bnn_pe_row_pipe

Interface
REQ-001 SHALL have parameter VEC_W, default 27: bits per PE slice.
REQ-002 SHALL have parameter ROW_LENGTH, default 7, legal range 2 or more: number of PE stages.
REQ-003 SHALL have parameter WIDTH, default 14: signed psum width.
REQ-004 SHALL have port clk_in, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: activation_in and psum_in are valid.
REQ-007 SHALL have port in_ready, output, 1: row accepts input this cycle.
REQ-008 SHALL have port activation_in, input, VEC_W*ROW_LENGTH: sliding-window bits; slice k (k=0 first stage) = bits [VEC_W*(ROW_LENGTH-k)-1 : VEC_W*(ROW_LENGTH-1-k)].
REQ-009 SHALL have port psum_in, input, WIDTH: signed partial sum from previous row.
REQ-010 SHALL have port weight_we, input, 1: load weight_in into weight register.
REQ-011 SHALL have port weight_in, input, VEC_W*ROW_LENGTH: weights, same slicing as activation_in.
REQ-012 SHALL have port activation_out, output, VEC_W*ROW_LENGTH: registered copy of the accepted activation_in, for the row below.
REQ-013 SHALL have port act_out_valid, output, 1: activation_out is valid.
REQ-014 SHALL have port psum_out, output, WIDTH: signed result.
REQ-015 SHALL have port out_sat, output, 1: saturation occurred for this psum_out.
REQ-016 SHALL have port out_valid, output, 1: psum_out is valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts psum_out.
REQ-018 SHALL have port busy, output, 1: any pipeline stage holds a valid item.

Function
REQ-019 Contribution of stage k SHALL be 2*popcount(XNOR(act slice k, weight slice k)) - VEC_W, range [-VEC_W, +VEC_W].
REQ-020 The pipeline SHALL have ROW_LENGTH register stages; stage k adds its contribution to the psum from stage k-1 (stage 0 uses psum_in).
REQ-021 Each stage SHALL carry forward only the activation slices still needed by later stages, plus the valid bit and a sticky saturation bit.
REQ-022 Latency SHALL be ROW_LENGTH cycles from accept (in_valid and in_ready) to out_valid, with no stall.
REQ-023 Throughput SHALL be one item per cycle while out_ready=1.
REQ-024 Stall SHALL be global: advance = !out_valid or out_ready. in_ready = advance. When stalled, all stages hold their contents.
REQ-025 psum_out, out_sat and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Each stage addition SHALL be computed at WIDTH+1 bits and clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; a clamp sets the item's sticky sat bit.
REQ-027 activation_out and act_out_valid SHALL update one cycle after accept. act_out_valid SHALL be 0 on cycles with no accept.
REQ-028 weight_we SHALL take effect on the next edge only when busy=0 and in_valid=0; otherwise it SHALL be ignored, and the weight register SHALL stay unchanged.
REQ-029 Weights SHALL be constant for every item resident in the pipeline.
REQ-030 Bubbles (in_valid=0 cycles) SHALL propagate as invalid stages and SHALL never produce out_valid.
REQ-031 busy SHALL be the OR of all stage valid bits.

Reset
REQ-032 On rst_in=0, all valid bits, act_out_valid, out_valid, out_sat and busy SHALL be 0 immediately (asynchronous), independent of clk_in.
REQ-033 On rst_in=0, psum_out, activation_out, pipeline data and weight register SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight items; no stale out_valid SHALL appear after release.
REQ-035 in_ready SHALL be 1 on the first cycle after reset release.

Verification (VEC_W=27, ROW_LENGTH=7, WIDTH=14)
REQ-036 Scenario: load weights all-1s; activation all-1s, psum_in=0 -> psum_out=189, out_sat=0, out_valid exactly 7 cycles after accept.
REQ-037 Scenario: activation all-0s with all-1s weights, psum_in=5 -> psum_out=-184. Then psum_in=-8100 -> psum_out=-8192, out_sat=1.
REQ-038 Scenario: 10 back-to-back items with out_ready=1 -> 10 consecutive out_valid cycles in order. Then hold out_ready=0 for 4 cycles mid-stream -> psum_out stable, in_ready=0, no item lost or duplicated.
REQ-039 Scenario: weight_we pulse while busy=1 -> in-flight and subsequent results use the old weights. The same pulse when idle -> new weights are used by the next item.
REQ-040 Scenario: assert rst_in=0 between clock edges with 3 items in flight -> out_valid, busy and act_out_valid go 0 at once, and no output appears after release.
REQ-041 Scenario: slice-order check -> slice 0 only matching (others mismatching), psum_in=0 -> psum_out = 27 - 6*27 = -135.
